// File: rtl/mem_post_write_buf.sv
// ---------------------------------------------------------------------------
// mem_post_write_buf
//
// Posted-write request buffer between the memory arbiter (upstream) and the
// memory controller (downstream). Writes are acknowledged as soon as they
// enter a circular queue and drain to the controller in FIFO order. A read
// waits until the queue is empty and then issues, so ordering stays strict.
//
// Optional feature (compile-time macro MEM_PWB_RAW_FORWARD_EN):
//   A READ whose cache line (addr[ADDR_WIDTH-1:6]) matches a queued write is
//   answered from the youngest matching queue entry without going downstream.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   u_op/u_addr/u_wdata upstream request (00 NOP, 01 READ, 10 WRITE, 11 NOP)
//   u_rdata             read data returned upstream (held until next read)
//   u_tx_done           one-cycle completion pulse upstream
//   u_rd_valid          one-cycle pulse, u_rdata valid
//   d_op/d_addr/d_wdata request to the memory controller (registered)
//   d_rdata             read data from the controller
//   d_tx_done           controller completion pulse
//   d_rd_valid          controller read-data-valid pulse
//   wq_count            number of queued writes
//   wq_full/wq_empty    queue status flags
// ---------------------------------------------------------------------------
module mem_post_write_buf #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              u_op,
  input  logic [ADDR_WIDTH-1:0]   u_addr,
  input  logic [DATA_WIDTH-1:0]   u_wdata,
  output logic [DATA_WIDTH-1:0]   u_rdata,
  output logic                    u_tx_done,
  output logic                    u_rd_valid,
  output logic [1:0]              d_op,
  output logic [ADDR_WIDTH-1:0]   d_addr,
  output logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH-1:0]   d_rdata,
  input  logic                    d_tx_done,
  input  logic                    d_rd_valid,
  output logic [$clog2(DEPTH):0]  wq_count,
  output logic                    wq_full,
  output logic                    wq_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic [1:0] {
    U_IDLE    = 2'd0,
    U_RD_WAIT = 2'd1,
    U_ACK     = 2'd2
  } u_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WR   = 2'd1,
    D_RD   = 2'd2
  } d_state_t;

  // Queue storage and bookkeeping
  logic [ADDR_WIDTH-1:0] r_q_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_q_data [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;

  // FSM state and registered outputs
  u_state_t              r_u_state, w_u_state_nxt;
  d_state_t              r_d_state, w_d_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [DATA_WIDTH-1:0] r_u_rdata, w_u_rdata_nxt;
  logic                  r_u_tx_done, w_u_tx_done_nxt;
  logic                  r_u_rd_valid, w_u_rd_valid_nxt;
  logic [1:0]            r_d_op, w_d_op_nxt;
  logic [ADDR_WIDTH-1:0] r_d_addr, w_d_addr_nxt;
  logic [DATA_WIDTH-1:0] r_d_wdata, w_d_wdata_nxt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_done;
  logic [CW-1:0]         w_count_nxt;

  // Downstream read completes on the controller's completion pulse in D_RD
  assign w_rd_done = (r_d_state == D_RD) && d_tx_done;

`ifdef MEM_PWB_RAW_FORWARD_EN
  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic [PW-1:0]         w_fwd_idx;

  // Line-match search over valid entries, oldest to youngest so the youngest hit wins
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_rd_ptr + i[PW-1:0];
      if ((CW'(i) < r_count) &&
          (r_q_addr[w_fwd_idx][ADDR_WIDTH-1:6] == u_addr[ADDR_WIDTH-1:6])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_q_data[w_fwd_idx];
      end else begin
        w_fwd_hit  = w_fwd_hit;
      end
    end
  end
`endif

  // Upstream FSM: next state, queue push and upstream response values
  always_comb begin
    w_u_state_nxt    = r_u_state;
    w_push           = 1'b0;
    w_u_tx_done_nxt  = 1'b0;
    w_u_rd_valid_nxt = 1'b0;
    w_rd_addr_nxt    = r_rd_addr;
    w_u_rdata_nxt    = r_u_rdata;
    case (r_u_state)
      U_IDLE: begin
        if (u_op == OP_WRITE) begin
          // A full queue stalls the write; it is re-evaluated every cycle
          if (!r_full) begin
            w_push          = 1'b1;
            w_u_tx_done_nxt = 1'b1;
            w_u_state_nxt   = U_ACK;
          end else begin
            w_u_state_nxt   = U_IDLE;
          end
        end else if (u_op == OP_READ) begin
`ifdef MEM_PWB_RAW_FORWARD_EN
          if (w_fwd_hit) begin
            w_u_rdata_nxt    = w_fwd_data;
            w_u_tx_done_nxt  = 1'b1;
            w_u_rd_valid_nxt = 1'b1;
            w_u_state_nxt    = U_ACK;
          end else begin
            w_rd_addr_nxt    = u_addr;
            w_u_state_nxt    = U_RD_WAIT;
          end
`else
          w_rd_addr_nxt = u_addr;
          w_u_state_nxt = U_RD_WAIT;
`endif
        end else begin
          // NOP and reserved op 11 are never accepted
          w_u_state_nxt = U_IDLE;
        end
      end
      U_RD_WAIT: begin
        // Read data may arrive before (or with) the completion pulse
        if ((r_d_state == D_RD) && d_rd_valid) begin
          w_u_rdata_nxt = d_rdata;
        end else begin
          w_u_rdata_nxt = r_u_rdata;
        end
        if (w_rd_done) begin
          w_u_tx_done_nxt  = 1'b1;
          w_u_rd_valid_nxt = 1'b1;
          w_u_state_nxt    = U_ACK;
        end else begin
          w_u_state_nxt    = U_RD_WAIT;
        end
      end
      U_ACK: begin
        // Bubble cycle: upstream is still holding the acknowledged op
        w_u_state_nxt = U_IDLE;
      end
      default: begin
        w_u_state_nxt = U_IDLE;
      end
    endcase
  end

  // Downstream FSM: next state, queue pop and controller request values
  always_comb begin
    w_d_state_nxt = r_d_state;
    w_pop         = 1'b0;
    w_d_op_nxt    = r_d_op;
    w_d_addr_nxt  = r_d_addr;
    w_d_wdata_nxt = r_d_wdata;
    case (r_d_state)
      D_IDLE: begin
        // Queued writes always go first, so a read never overtakes a write
        if (!r_empty) begin
          w_d_state_nxt = D_WR;
          w_d_op_nxt    = OP_WRITE;
          w_d_addr_nxt  = r_q_addr[r_rd_ptr];
          w_d_wdata_nxt = r_q_data[r_rd_ptr];
        end else if (r_u_state == U_RD_WAIT) begin
          w_d_state_nxt = D_RD;
          w_d_op_nxt    = OP_READ;
          w_d_addr_nxt  = r_rd_addr;
          w_d_wdata_nxt = '0;
        end else begin
          w_d_state_nxt = D_IDLE;
          w_d_op_nxt    = OP_NOP;
        end
      end
      D_WR: begin
        if (d_tx_done) begin
          w_pop         = 1'b1;
          w_d_op_nxt    = OP_NOP;
          w_d_state_nxt = D_IDLE;
        end else begin
          w_d_state_nxt = D_WR;
        end
      end
      D_RD: begin
        if (d_tx_done) begin
          w_d_op_nxt    = OP_NOP;
          w_d_state_nxt = D_IDLE;
        end else begin
          w_d_state_nxt = D_RD;
        end
      end
      default: begin
        w_d_op_nxt    = OP_NOP;
        w_d_state_nxt = D_IDLE;
      end
    endcase
  end

  // Occupancy update; push is only ever granted below DEPTH so no overflow
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // State, pointer, flag and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_u_state    <= U_IDLE;
      r_d_state    <= D_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_rd_addr    <= '0;
      r_u_rdata    <= '0;
      r_u_tx_done  <= 1'b0;
      r_u_rd_valid <= 1'b0;
      r_d_op       <= OP_NOP;
      r_d_addr     <= '0;
      r_d_wdata    <= '0;
    end else begin
      r_u_state    <= w_u_state_nxt;
      r_d_state    <= w_d_state_nxt;
      r_wr_ptr     <= w_push ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
      r_rd_ptr     <= w_pop  ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
      r_count      <= w_count_nxt;
      r_full       <= (w_count_nxt == CW'(DEPTH));
      r_empty      <= (w_count_nxt == CW'(0));
      r_rd_addr    <= w_rd_addr_nxt;
      r_u_rdata    <= w_u_rdata_nxt;
      r_u_tx_done  <= w_u_tx_done_nxt;
      r_u_rd_valid <= w_u_rd_valid_nxt;
      r_d_op       <= w_d_op_nxt;
      r_d_addr     <= w_d_addr_nxt;
      r_d_wdata    <= w_d_wdata_nxt;
    end
  end

  // Queue payload storage; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= u_addr;
      r_q_data[r_wr_ptr] <= u_wdata;
    end
  end

  assign u_rdata    = r_u_rdata;
  assign u_tx_done  = r_u_tx_done;
  assign u_rd_valid = r_u_rd_valid;
  assign d_op       = r_d_op;
  assign d_addr     = r_d_addr;
  assign d_wdata    = r_d_wdata;
  assign wq_count   = r_count;
  assign wq_full    = r_full;
  assign wq_empty   = r_empty;

endmodule
